// File: rtl/throw_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : throw_turn_ctrl
// Description : Per-turn throw engine. It charges power from the owner's fire
//               button, times the projectile flight, resolves hit/miss and
//               owns both HP registers. Optional AIM forfeit: TURN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module throw_turn_ctrl #(
    parameter int unsigned HP_MAX     = 100,
    parameter int unsigned DMG        = 20,
    parameter int unsigned PWR_MAX    = 255,
    parameter int unsigned CHARGE_DIV = 4,
    parameter int unsigned TARGET_PWR = 160,
    parameter int unsigned HIT_TOL    = 12,
    parameter int unsigned FLIGHT_CYC = 64
`ifdef TURN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_idle,
    input  logic       next_turn,
    input  logic       dog_turn,
    input  logic       cat_turn,
    input  logic       fire_local,
    input  logic       fire_remote,
    output logic       turn_done_dog,
    output logic       turn_done_cat,
    output logic [9:0] hp_dog,
    output logic [9:0] hp_cat,
    output logic [7:0] power,
    output logic       proj_active,
    output logic       hit
);

    localparam int unsigned DIV_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam int unsigned FLT_W = (FLIGHT_CYC > 1) ? $clog2(FLIGHT_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHARGE_DIV - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FLIGHT_CYC - 1);
    // The press cycle itself counts as the first charge cycle.
    localparam logic [DIV_W-1:0] DIV_FIRST = (CHARGE_DIV > 1) ? DIV_W'(1) : '0;
    localparam logic [7:0]       PWR_FIRST = (CHARGE_DIV > 1) ? 8'd0 : 8'd1;
    localparam logic [9:0]       HP_INIT   = 10'(HP_MAX);
    localparam logic [9:0]       DMG_V     = 10'(DMG);
    localparam logic [7:0]       PWR_SAT   = 8'(PWR_MAX);
    localparam logic [8:0]       TARGET_V  = 9'(TARGET_PWR);
    localparam logic [8:0]       TOL_V     = 9'(HIT_TOL);
`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AIM     = 3'd1,
        S_CHARGE  = 3'd2,
        S_FLIGHT  = 3'd3,
        S_RESOLVE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             owner_dog_q, owner_dog_d;
    logic             fire_prev_q, fire_prev_d;
    logic [7:0]       power_q, power_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [FLT_W-1:0] flt_q, flt_d;
    logic             hit_q, hit_d;
    logic [9:0]       hp_dog_q, hp_dog_d;
    logic [9:0]       hp_cat_q, hp_cat_d;
    logic             done_dog_q, done_dog_d;
    logic             done_cat_q, done_cat_d;
`ifdef TURN_TIMEOUT_EN
    logic [TO_W-1:0]  to_q, to_d;
`endif

    logic              fire_idle_sel;
    logic              fire;
    logic              fire_rise;
    logic signed [8:0] diff;
    logic [8:0]        abs_diff;
    logic              hit_now;
    logic [9:0]        target_hp;
    logic [9:0]        dmg_hp;

    // In IDLE the owner is not latched yet, so follow the live turn flags;
    // this primes fire_prev so a button held at turn entry is not an edge.
    assign fire_idle_sel = dog_turn ? fire_local : (cat_turn ? fire_remote : 1'b0);
    assign fire          = (state_q == S_IDLE) ? fire_idle_sel
                                               : (owner_dog_q ? fire_local : fire_remote);
    assign fire_rise     = fire && !fire_prev_q;

    assign diff      = $signed({1'b0, power_q}) - $signed(TARGET_V);
    assign abs_diff  = diff[8] ? 9'(-diff) : 9'(diff);
    assign hit_now   = (abs_diff <= TOL_V);
    assign target_hp = owner_dog_q ? hp_cat_q : hp_dog_q;
    assign dmg_hp    = (target_hp < DMG_V) ? 10'd0 : (target_hp - DMG_V);

    always_comb begin
        state_d     = state_q;
        owner_dog_d = owner_dog_q;
        fire_prev_d = fire;
        power_d     = power_q;
        div_d       = div_q;
        flt_d       = flt_q;
        hit_d       = hit_q;
        hp_dog_d    = hp_dog_q;
        hp_cat_d    = hp_cat_q;
        done_dog_d  = 1'b0;
        done_cat_d  = 1'b0;
`ifdef TURN_TIMEOUT_EN
        to_d        = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (game_idle) begin
                    hp_dog_d = HP_INIT;
                    hp_cat_d = HP_INIT;
                    power_d  = 8'd0;
                    hit_d    = 1'b0;
                end
                if (next_turn && (dog_turn ^ cat_turn)) begin
                    state_d     = S_AIM;
                    owner_dog_d = dog_turn;
`ifdef TURN_TIMEOUT_EN
                    to_d        = '0;
`endif
                end
            end
            S_AIM: begin
                if (!next_turn) begin
                    state_d = S_IDLE;
                end else if (fire_rise) begin
                    state_d = S_CHARGE;
                    power_d = PWR_FIRST;
                    div_d   = DIV_FIRST;
                    hit_d   = 1'b0;
                end
`ifdef TURN_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    state_d    = S_DONE;
                    power_d    = 8'd0;
                    hit_d      = 1'b0;
                    done_dog_d = owner_dog_q;
                    done_cat_d = !owner_dog_q;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_CHARGE: begin
                if (!next_turn) begin
                    state_d = S_IDLE;
                end else if (!fire) begin
                    state_d = S_FLIGHT;
                    flt_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (power_q != PWR_SAT) begin
                        power_d = power_q + 8'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_FLIGHT: begin
                if (!next_turn) begin
                    state_d = S_IDLE;
                end else if (flt_q == FLT_LAST) begin
                    state_d = S_RESOLVE;
                end else begin
                    flt_d = flt_q + 1'b1;
                end
            end
            S_RESOLVE: begin
                if (!next_turn) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    hit_d   = hit_now;
                    if (hit_now) begin
                        if (owner_dog_q) hp_cat_d = dmg_hp;
                        else             hp_dog_d = dmg_hp;
                    end
                    // Registered pulse lands in the same cycle the new HP is visible.
                    done_dog_d = owner_dog_q;
                    done_cat_d = !owner_dog_q;
                end
            end
            S_DONE: begin
                if (!next_turn) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_dog_q <= 1'b0;
            fire_prev_q <= 1'b0;
            power_q     <= 8'd0;
            div_q       <= '0;
            flt_q       <= '0;
            hit_q       <= 1'b0;
            hp_dog_q    <= HP_INIT;
            hp_cat_q    <= HP_INIT;
            done_dog_q  <= 1'b0;
            done_cat_q  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_dog_q <= owner_dog_d;
            fire_prev_q <= fire_prev_d;
            power_q     <= power_d;
            div_q       <= div_d;
            flt_q       <= flt_d;
            hit_q       <= hit_d;
            hp_dog_q    <= hp_dog_d;
            hp_cat_q    <= hp_cat_d;
            done_dog_q  <= done_dog_d;
            done_cat_q  <= done_cat_d;
`ifdef TURN_TIMEOUT_EN
            to_q        <= to_d;
`endif
        end
    end

    assign turn_done_dog = done_dog_q;
    assign turn_done_cat = done_cat_q;
    assign hp_dog        = hp_dog_q;
    assign hp_cat        = hp_cat_q;
    assign power         = power_q;
    assign proj_active   = (state_q == S_FLIGHT);
    assign hit           = hit_q;

endmodule
`default_nettype wire
